pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the pipelined CPU. It generalises the fixed five-stage flow control to a configurable number of post-decode stages (`DEPTH`) and a configurable multi-cycle unit latency. The block tracks in-flight destination addresses in an internal shadow pipeline. Each cycle it drives a per-stage `cond` code and two forwarding results for the ID stage.

## Interface
Parameters:
- `ADDR_W`, 7: flow address width (GPR/HI/LO/CP0 space); address 0 means no register.
- `DATA_W`, 32: datapath width.
- `DEPTH`, 3: number of tracked post-decode stage registers (EX, ME, WB with the default).
- `MD_LAT`, 32: multi-cycle (mult/div) freeze length in cycles, ≥2.

Ports (the clock is `clk`; `reset` is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cpu_stall` in 1: external freeze.
- `id_valid` in 1: ID holds a real instruction.
- `id_raddr1`, `id_raddr2` in `ADDR_W`: ID source addresses.
- `id_waddr` in `ADDR_W`: ID destination address.
- `id_is_load` in 1: ID instruction's result comes from data memory.
- `id_is_md` in 1: ID instruction is a multi-cycle op.
- `branch_taken` in 1: ID resolved a taken branch.
- `stage_data` in `DEPTH*DATA_W`: slice k-1 holds the result in stage-k output register (k=1..DEPTH).
- `cond` out `2*(DEPTH+2)`: slice s is the code for stage s (0=IF, 1=ID, 2..DEPTH+1 downstream). Codes: 00 run, 01 hold, 10 bubble.
- `fwd_a_hit`, `fwd_b_hit` out 1: the matching forwarding data is valid.
- `fwd_a_data`, `fwd_b_data` out `DATA_W`: forwarded operand.
- `md_busy` out 1: multi-cycle freeze active.
- `md_done` out 1: one-cycle pulse on the last freeze cycle.

## Operation
- Shadow pipeline: registers `wa[k]` and `ld[k]`, k=1..DEPTH.
  - Advance: `wa[1]` ← `id_waddr` if ID issues, else 0. Then `wa[k]` ← `wa[k-1]`, with `ld` following the same path.
  - An issued instruction has `id_valid`=1 and is neither stalled nor bubbled.
- Match: for each nonzero read address r, select the smallest k with `wa[k]`==r (nearest writer wins). Address 0 never matches.
- Load-use: a match at k=1 with `ld[1]`=1 is a load-use hazard.
  - `cond`: IF=01, ID=10, downstream=00.
  - `wa[1]` ← 0 while the rest of the shadow pipeline advances.
- Forwarding: a non-load-use match sets hit=1 and data=`stage_data` slice k-1. With no match, hit=0 and data=0.
- Multi-cycle: a `id_is_md` instruction issuing starts a freeze counter at MD_LAT.
  - While the counter is nonzero, `md_busy`=1, all `cond`=01, and the shadow pipeline holds. The counter decrements each cycle.
  - `md_done`=1 when the counter equals 1.
- Flush: `branch_taken` with no stall condition gives IF=10; all other stages 00.
- Priority (highest first): reset, `cpu_stall` (all 01, no state change, counter frozen), `md_busy`, load-use, flush, run.
- `branch_taken` is ignored while ID is held or bubbled.
- `id_is_md` arriving during a load-use stall does not issue and does not start the counter.

## Timing
- `cond`, `fwd_*` and hit are combinational from the inputs and shadow state within the same cycle. `md_busy` and `md_done` decode the registered counter.
- Reset (one or more cycles): `wa`/`ld` ← 0, counter ← 0. While `reset` is high, `cond` = all 10, hits=0, data=0, `md_busy`=0, `md_done`=0.
- Reset mid-freeze aborts the freeze; the first cycle after reset is a run cycle.
- Load-use costs exactly one bubble. The next cycle the load sits at k=2 and forwards `stage_data` slice 1.
- A md op issued in cycle N freezes cycles N+1..N+MD_LAT (`md_done` in N+MD_LAT). The pipeline advances again in N+MD_LAT+1.
- `cpu_stall` during a freeze extends the freeze one cycle per stalled cycle.

## Configuration
- `HAZ_FORWARD_EN` defined: forwarding as described above.
- `HAZ_FORWARD_EN` undefined: interlock only.
  - Any match at any k drives the load-use stall pattern until no match remains.
  - `fwd_*_hit` and `fwd_*_data` are tied to 0.

## Test plan
- Reset held 2 cycles → `cond`=all 10, `md_busy`=0. First cycle after reset: `cond`=all 00.
- ALU writer `id_waddr`=5 issues, then `id_raddr1`=5 next cycle with `stage_data` slice0=0x1234 → `fwd_a_hit`=1, `fwd_a_data`=0x1234, no stall. The same raddr with writers at k=1 and k=2 → k=1 data chosen.
- Load to r8 followed by a reader of r8 → one cycle IF=01, ID=10. Next cycle `fwd_b_hit`=1 from slice 1, `cond`=all 00.
- MD op issued in cycle 10 with MD_LAT=32 → `md_busy` cycles 11..42, `md_done` at 42, run at 43. Asserting `cpu_stall` at cycle 20 moves `md_done` to 43.
- `branch_taken`=1 with no hazard → IF=10 for one cycle. Together with a load-use hazard → stall pattern only, no flush.
- With `HAZ_FORWARD_EN` undefined: ALU writer r3 then reader r3 → stall held until `wa` no longer contains 3 (DEPTH cycles), hits always 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard, forwarding and stall controller for a pipeline with DEPTH tracked
// post-decode stages.  A shadow pipeline of destination addresses (wa) and
// load flags (ld) mirrors the real stage registers so that the ID-stage source
// operands can be matched against in-flight writers.  A freeze counter models
// multi-cycle (mult/div) operations.
//
// Build option:
//   HAZ_FORWARD_EN  defined   -> operands are forwarded from stage_data; only a
//                                load at the first stage stalls (one bubble).
//                   undefined -> interlock only: any in-flight writer of a
//                                source operand stalls ID; forwarding is 0.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cpu_stall         external freeze (highest priority after reset)
//   id_valid          ID holds a real instruction
//   id_raddr1/2       ID source addresses (0 = no register)
//   id_waddr          ID destination address
//   id_is_load        ID result comes from data memory
//   id_is_md          ID instruction is a multi-cycle op
//   branch_taken      ID resolved a taken branch
//   stage_data        slice k-1 = result held in stage-k output register
//   cond              2-bit code per stage (slice 0 = IF, 1 = ID, 2.. downstream)
//                     00 run, 01 hold, 10 bubble
//   fwd_a/b_hit/data  forwarding result for each ID operand
//   md_busy, md_done  multi-cycle freeze active / last freeze cycle
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 3,
  parameter int MD_LAT = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_stall,
  input  logic                      id_valid,
  input  logic [ADDR_W-1:0]         id_raddr1,
  input  logic [ADDR_W-1:0]         id_raddr2,
  input  logic [ADDR_W-1:0]         id_waddr,
  input  logic                      id_is_load,
  input  logic                      id_is_md,
  input  logic                      branch_taken,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  output logic [2*(DEPTH+2)-1:0]    cond,
  output logic                      fwd_a_hit,
  output logic                      fwd_b_hit,
  output logic [DATA_W-1:0]         fwd_a_data,
  output logic [DATA_W-1:0]         fwd_b_data,
  output logic                      md_busy,
  output logic                      md_done
);

  localparam int NSTG  = DEPTH + 2;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(MD_LAT + 1);

  localparam logic [1:0] C_RUN    = 2'b00;
  localparam logic [1:0] C_HOLD   = 2'b01;
  localparam logic [1:0] C_BUBBLE = 2'b10;

  // Shadow pipeline; index k-1 holds stage k.
  logic [ADDR_W-1:0] wa_q [DEPTH];
  logic [ADDR_W-1:0] wa_d [DEPTH];
  logic [DEPTH-1:0]  ld_q, ld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              md_active;
  logic              hazard;
  logic              issue;
  logic              a_found, b_found;
  logic [IDX_W-1:0]  a_idx, b_idx;

  assign md_active = (cnt_q != '0);

  // Nearest-writer search: scanning from the far end down to stage 1 lets the
  // last assignment (smallest k) win.  Address 0 is "no register" and never
  // matches, even though empty shadow slots also hold 0.
  always_comb begin
    a_found = 1'b0;
    a_idx   = '0;
    b_found = 1'b0;
    b_idx   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if ((id_raddr1 != '0) && (wa_q[k] == id_raddr1)) begin
        a_found = 1'b1;
        a_idx   = IDX_W'(k);
      end
      if ((id_raddr2 != '0) && (wa_q[k] == id_raddr2)) begin
        b_found = 1'b1;
        b_idx   = IDX_W'(k);
      end
    end
  end

`ifdef HAZ_FORWARD_EN
  logic              a_lu, b_lu;
  logic [DATA_W-1:0] stage_arr [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage_slice
      assign stage_arr[gi] = stage_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A load whose result is not yet out of memory cannot be forwarded.
  assign a_lu   = a_found && (a_idx == '0) && ld_q[0];
  assign b_lu   = b_found && (b_idx == '0) && ld_q[0];
  assign hazard = id_valid && (a_lu || b_lu);

  assign fwd_a_hit  = !reset && a_found && !a_lu;
  assign fwd_b_hit  = !reset && b_found && !b_lu;
  assign fwd_a_data = fwd_a_hit ? stage_arr[a_idx] : '0;
  assign fwd_b_data = fwd_b_hit ? stage_arr[b_idx] : '0;
`else
  logic unused_cfg;

  // Without forwarding every in-flight writer of a source blocks ID.
  assign hazard     = id_valid && (a_found || b_found);
  assign fwd_a_hit  = 1'b0;
  assign fwd_b_hit  = 1'b0;
  assign fwd_a_data = '0;
  assign fwd_b_data = '0;
  assign unused_cfg = ^{stage_data, a_idx, b_idx};
`endif

  // Load flags past stage 1 only ride along with their instruction.
  logic unused_ld;
  assign unused_ld = ^ld_q;

  assign issue = !reset && id_valid && !cpu_stall && !md_active && !hazard;

  // Per-stage condition codes, highest priority first.
  always_comb begin
    cond = '0;
    if (reset) begin
      for (int s = 0; s < NSTG; s++) cond[2*s +: 2] = C_BUBBLE;
    end else if (cpu_stall || md_active) begin
      for (int s = 0; s < NSTG; s++) cond[2*s +: 2] = C_HOLD;
    end else if (hazard) begin
      cond[1:0] = C_HOLD;
      cond[3:2] = C_BUBBLE;
    end else if (branch_taken) begin
      cond[1:0] = C_BUBBLE;
    end else begin
      cond[1:0] = C_RUN;
    end
  end

  // Shadow pipeline advance.  A load-use stall needs no special case: the
  // stalled instruction does not issue, so a zero enters stage 1.
  always_comb begin
    wa_d = wa_q;
    ld_d = ld_q;
    if (!cpu_stall && !md_active) begin
      wa_d[0] = issue ? id_waddr : '0;
      ld_d[0] = issue && id_is_load;
      for (int k = 1; k < DEPTH; k++) begin
        wa_d[k] = wa_q[k-1];
        ld_d[k] = ld_q[k-1];
      end
    end
  end

  // Freeze counter: loaded by an issuing md op, counts down while busy,
  // frozen by cpu_stall (which therefore stretches the freeze).
  always_comb begin
    cnt_d = cnt_q;
    if (!cpu_stall) begin
      if (md_active) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (issue && id_is_md) begin
        cnt_d = CNT_W'(MD_LAT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) wa_q[k] <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
    end else begin
      wa_q  <= wa_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
    end
  end

  assign md_busy = !reset && md_active;
  assign md_done = !reset && (cnt_q == CNT_W'(1));

endmodule
